// File: rtl/board_io_pkg.sv
// Shared constants for the board I/O front end: LEDG bit map, SW field
// offsets and counter-width helpers.
package board_io_pkg;

   // LEDG bit map
   localparam int STEP_BIT      = 0;
   localparam int HEARTBEAT_BIT = 1;
   localparam int INIT_BIT      = 2;
   localparam int PEND_BIT      = 3;
   localparam int STATE_LSB     = 4;

   // SW field offsets: [DATA_W-1:0] data, then Initialize, then Enter
   function automatic int init_idx(input int data_w);
      return data_w;
   endfunction

   function automatic int enter_idx(input int data_w);
      return data_w + 1;
   endfunction

   // Debounce counter width, shared by every debouncer instance
   function automatic int db_cnt_w(input int db_cyc);
      return $clog2(db_cyc + 1);
   endfunction

   // Width of a counter that runs 0..n-1 (at least one bit)
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: 2-FF synchroniser followed by a stability counter.
// The debounced level only follows the synchronised input after it has
// differed from the current level for DB_CYC consecutive cycles.
module sw_debounce
   import board_io_pkg::*;
#(
   parameter int DB_CYC = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level
);

   localparam int CW = db_cnt_w(DB_CYC);

   logic          meta_q, sync_q;
   logic          stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Count while the synchronised input disagrees; commit on the last count
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync_q != stable_q) begin
         if (cnt_q == CW'(DB_CYC - 1)) stable_d = sync_q;
         else                          cnt_d    = cnt_q + 1'b1;
      end
   end

   // Synchroniser and debounce state
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q   <= 1'b0;
         sync_q   <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         meta_q   <= raw;
         sync_q   <= meta_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign level = stable_q;

endmodule

// File: rtl/board_io_frontend.sv
// Board I/O front end for the EC2 core: tick (clock-enable) generator,
// debounced switches, one-shot Enter request and status LEDs.
// Optional single-step control is compiled in with STEP_MODE_EN.
module board_io_frontend
   import board_io_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int DIV         = 50000000,
   parameter int DB_CYC      = 500000,
   parameter int BLINK_TICKS = 1
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [DATA_W+1:0] SW,
   input  logic              proc_halt,
   input  logic [DATA_W-1:0] proc_out,
   input  logic [3:0]        proc_state,
`ifdef STEP_MODE_EN
   input  logic              step_mode,
   input  logic              KEY_STEP,
`endif
   output logic              tick,
   output logic [DATA_W-1:0] data_in,
   output logic              enter_pulse,
   output logic              init_lvl,
   output logic [DATA_W:0]   LEDR,
   output logic [7:0]        LEDG
);

   localparam int INIT_I  = init_idx(DATA_W);
   localparam int ENTER_I = enter_idx(DATA_W);
   localparam int DIV_W   = cnt_w(DIV);
   localparam int BLK_W   = cnt_w(BLINK_TICKS);

   logic [DATA_W+1:0] sw_db;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              div_hit, tick_raw;
   logic              enter_prev_q, enter_rise;
   logic              pend_q, pend_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic [3:0]        state_q, state_d;
   logic              halt_prev_q;
   logic              blink_q, blink_d;
   logic [BLK_W-1:0]  blink_cnt_q, blink_cnt_d;
   logic              hb_q, hb_d;
   logic [BLK_W-1:0]  hb_cnt_q, hb_cnt_d;
   logic              step_led;

   // Every switch bit gets its own synchroniser and debouncer
   for (genvar i = 0; i < DATA_W + 2; i++) begin : g_sw
      sw_debounce #(.DB_CYC(DB_CYC)) u_db (
         .clk   (Clock),
         .rst   (Reset),
         .raw   (SW[i]),
         .level (sw_db[i])
      );
   end

`ifdef STEP_MODE_EN
   logic step_db, key_db, key_prev_q;

   sw_debounce #(.DB_CYC(DB_CYC)) u_db_step (
      .clk   (Clock),
      .rst   (Reset),
      .raw   (step_mode),
      .level (step_db)
   );

   sw_debounce #(.DB_CYC(DB_CYC)) u_db_key (
      .clk   (Clock),
      .rst   (Reset),
      .raw   (KEY_STEP),
      .level (key_db)
   );

   // Remember the debounced key so a press (1->0) can be seen as an edge
   always_ff @(posedge Clock) begin
      if (Reset) key_prev_q <= 1'b0;
      else       key_prev_q <= key_db;
   end

   assign step_led = step_db;

   // Step mode parks the divider at 0 and ticks once per key press
   always_comb begin
      div_hit  = (div_q == DIV_W'(DIV - 1));
      tick_raw = step_db ? (key_prev_q & ~key_db) : div_hit;
      div_d    = (step_db || div_hit) ? '0 : div_q + 1'b1;
   end
`else
   assign step_led = 1'b0;

   // Free-running divider; tick in the last count of each period
   always_comb begin
      div_hit  = (div_q == DIV_W'(DIV - 1));
      tick_raw = div_hit;
      div_d    = div_hit ? '0 : div_q + 1'b1;
   end
`endif

   // Reset is synchronous, so the combinational tick is masked directly
   assign tick = tick_raw & ~Reset;

   // Enter request: latch data on a debounced rising edge, hold until a tick
   always_comb begin
      enter_rise = sw_db[ENTER_I] & ~enter_prev_q;
      pend_d     = pend_q;
      data_d     = data_q;
      if (pend_q) begin
         if (tick) pend_d = 1'b0;
      end else if (enter_rise) begin
         pend_d = 1'b1;
         data_d = sw_db[DATA_W-1:0];
      end
   end

   // Core status capture, halt blink and heartbeat
   always_comb begin
      out_d       = out_q;
      state_d     = state_q;
      blink_d     = blink_q;
      blink_cnt_d = blink_cnt_q;
      hb_d        = hb_q;
      hb_cnt_d    = hb_cnt_q;

      if (tick) begin
         out_d   = proc_out;
         state_d = proc_state;
      end

      // Halt rising restarts the blink in the lit phase
      if (!proc_halt) begin
         blink_d     = 1'b0;
         blink_cnt_d = '0;
      end else if (!halt_prev_q) begin
         blink_d     = 1'b1;
         blink_cnt_d = '0;
      end else if (tick) begin
         if (blink_cnt_q == BLK_W'(BLINK_TICKS - 1)) begin
            blink_d     = ~blink_q;
            blink_cnt_d = '0;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end

      if (tick) begin
         if (hb_cnt_q == BLK_W'(BLINK_TICKS - 1)) begin
            hb_d     = ~hb_q;
            hb_cnt_d = '0;
         end else begin
            hb_cnt_d = hb_cnt_q + 1'b1;
         end
      end
   end

   // State registers
   always_ff @(posedge Clock) begin
      if (Reset) begin
         div_q        <= '0;
         enter_prev_q <= 1'b0;
         pend_q       <= 1'b0;
         data_q       <= '0;
         out_q        <= '0;
         state_q      <= '0;
         halt_prev_q  <= 1'b0;
         blink_q      <= 1'b0;
         blink_cnt_q  <= '0;
         hb_q         <= 1'b0;
         hb_cnt_q     <= '0;
      end else begin
         div_q        <= div_d;
         enter_prev_q <= sw_db[ENTER_I];
         pend_q       <= pend_d;
         data_q       <= data_d;
         out_q        <= out_d;
         state_q      <= state_d;
         halt_prev_q  <= proc_halt;
         blink_q      <= blink_d;
         blink_cnt_q  <= blink_cnt_d;
         hb_q         <= hb_d;
         hb_cnt_q     <= hb_cnt_d;
      end
   end

   // Output assembly
   always_comb begin
      LEDG                     = '0;
      LEDG[STATE_LSB +: 4]     = state_q;
      LEDG[PEND_BIT]           = pend_q;
      LEDG[INIT_BIT]           = sw_db[INIT_I];
      LEDG[HEARTBEAT_BIT]      = hb_q;
      LEDG[STEP_BIT]           = step_led;
   end

   assign data_in     = data_q;
   assign enter_pulse = pend_q;
   assign init_lvl    = sw_db[INIT_I];
   assign LEDR        = {out_q, blink_q};

endmodule

// File: tb/tb_board_io_frontend.sv
// Directed bench for board_io_frontend (DATA_W=8, DIV=4, DB_CYC=3,
// BLINK_TICKS=2). Enter data and tick-captured LED values are checked
// through scoreboards; step-mode checks are built with STEP_MODE_EN.
module tb_board_io_frontend;
   import board_io_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] sw;
   logic       proc_halt;
   logic [7:0] proc_out;
   logic [3:0] proc_state;
   logic       tick, enter_pulse, init_lvl;
   logic [7:0] data_in;
   logic [8:0] ledr;
   logic [7:0] ledg;
`ifdef STEP_MODE_EN
   logic       step_mode = 1'b0;
   logic       key_step  = 1'b1;
`endif

   int compared   = 0;
   int mismatched = 0;
   int tick_seen  = 0;
   int pulse_ticks = 0;
   logic pulse_prev = 1'b0;
   logic led_chk = 1'b0;
   logic [11:0] exp_led;
   logic [7:0]  sb_enter[$];
   logic [11:0] sb_led[$];

   board_io_frontend #(.DATA_W(8), .DIV(4), .DB_CYC(3), .BLINK_TICKS(2)) dut (
      .Clock       (clk),
      .Reset       (rst),
      .SW          (sw),
      .proc_halt   (proc_halt),
      .proc_out    (proc_out),
      .proc_state  (proc_state),
`ifdef STEP_MODE_EN
      .step_mode   (step_mode),
      .KEY_STEP    (key_step),
`endif
      .tick        (tick),
      .data_in     (data_in),
      .enter_pulse (enter_pulse),
      .init_lvl    (init_lvl),
      .LEDR        (ledr),
      .LEDG        (ledg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Bounded wait until tick is high at a negedge (current one included)
   task automatic wait_tick();
      int n = 0;
      while (!tick && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("tick_timeout", tick, 1'b1);
   endtask

   // Scoreboard monitors: Enter data at pulse start, one tick per pulse,
   // LED capture on the cycle after a tick
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (tick) tick_seen++;
         if (enter_pulse && !pulse_prev) begin
            chk("enter_sb_avail", sb_enter.size() > 0, 1'b1);
            if (sb_enter.size() > 0) begin
               e = sb_enter.pop_front();
               chk("data_in", data_in, e);
            end
            pulse_ticks = 0;
         end
         if (!enter_pulse && pulse_prev) chk("enter_ticks", pulse_ticks, 1);
         if (enter_pulse && tick) pulse_ticks++;
         pulse_prev = enter_pulse;
         if (led_chk) begin
            chk("ledr_out", ledr[8:1], exp_led[11:4]);
            chk("ledg_state", ledg[STATE_LSB +: 4], exp_led[3:0]);
            led_chk = 1'b0;
         end
         if (tick && sb_led.size() > 0) begin
            exp_led = sb_led.pop_front();
            led_chk = 1'b1;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; sw = 10'h3FF; proc_halt = 1'b0; proc_out = 8'h00; proc_state = 4'h0;
      sb_enter.push_back(8'hFF);
      cyc(3);
      chk("rst_tick", tick, 1'b0);
      chk("rst_data_in", data_in, 8'h00);
      chk("rst_enter", enter_pulse, 1'b0);
      chk("rst_init", init_lvl, 1'b0);
      chk("rst_ledr", ledr, 9'h000);
      chk("rst_ledg", ledg, 8'h00);

      // Idle after release: tick period, debounce latency, heartbeat, Enter
      rst = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         cyc(1);
         chk("idle_tick", tick, (k % 4) == 3);
         chk("idle_init", init_lvl, k >= 5);
         chk("idle_hb", ledg[HEARTBEAT_BIT], ((k / 8) % 2) == 1);
         chk("idle_enter", enter_pulse, (k == 6) || (k == 7));
      end
      chk("idle_ledr", ledr, 9'h000);

      // Two-cycle glitch on Initialize is filtered
      sw[8] = 1'b0; cyc(2); sw[8] = 1'b1;
      for (int j = 0; j < 8; j++) begin
         cyc(1);
         chk("glitch_init", init_lvl, 1'b1);
      end

      // Held change propagates after 2 + DB_CYC cycles
      sw[8] = 1'b0;
      for (int j = 1; j <= 5; j++) begin
         cyc(1);
         chk("hold_init", init_lvl, j < 5);
      end
      sw[8] = 1'b1; cyc(6);
      chk("hold_init_back", init_lvl, 1'b1);

      // Falling Enter does nothing
      sw[9] = 1'b0; cyc(6);
      chk("fall_enter", enter_pulse, 1'b0);
      chk("fall_data", data_in, 8'hFF);

      // Enter with A5; SW[0] glitch at the same time, data change and raw
      // Enter toggle while pending must not disturb the latched value
      sw[7:0] = 8'hA5; cyc(6);
      sb_enter.push_back(8'hA5);
      sw[9] = 1'b1; sw[0] = 1'b0; cyc(2);
      sw[7:0] = 8'h3B; cyc(4);
      sw[9] = 1'b0; cyc(2);
      sw[9] = 1'b1; cyc(8);
      chk("enter_done", enter_pulse, 1'b0);
      chk("enter_hold_data", data_in, 8'hA5);

      // Halt blink and tick-captured status
      proc_halt = 1'b1; proc_out = 8'h3C; proc_state = 4'h9;
      sb_led.push_back({8'h3C, 4'h9});
      cyc(1);
      chk("blink_start", ledr[0], 1'b1);
      wait_tick(); cyc(1);
      chk("blink_t1", ledr[0], 1'b1);
      wait_tick(); cyc(1);
      chk("blink_t2", ledr[0], 1'b0);
      wait_tick(); cyc(1);
      chk("blink_t3", ledr[0], 1'b0);
      wait_tick(); cyc(1);
      chk("blink_t4", ledr[0], 1'b1);
      proc_halt = 1'b0; cyc(1);
      chk("blink_off", ledr[0], 1'b0);
      chk("ledr_hold", ledr[8:1], 8'h3C);

      // Reset mid-operation: no ticks, everything cleared
      proc_halt = 1'b1; cyc(3);
      rst = 1'b1; sw = 10'h000;
      chk("mid_rst_tick0", tick, 1'b0);
      for (int j = 0; j < 4; j++) begin
         cyc(1);
         chk("mid_rst_tick", tick, 1'b0);
         chk("mid_rst_ledr", ledr, 9'h000);
         chk("mid_rst_ledg", ledg, 8'h00);
         chk("mid_rst_enter", enter_pulse, 1'b0);
      end
      rst = 1'b0; proc_halt = 1'b0; cyc(2);

`ifdef STEP_MODE_EN
      begin
         int t0;
         step_mode = 1'b1; cyc(8);
         chk("step_led_on", ledg[STEP_BIT], 1'b1);
         t0 = tick_seen;
         for (int p = 0; p < 3; p++) begin
            key_step = 1'b0; cyc(6);
            key_step = 1'b1; cyc(6);
         end
         chk("step_ticks", tick_seen - t0, 3);
         step_mode = 1'b0;
         for (int j = 1; j <= 8; j++) begin
            cyc(1);
            chk("step_exit_tick", tick, j == 8);
            chk("step_exit_led", ledg[STEP_BIT], j < 5);
         end
      end
`else
      chk("step_led_off", ledg[STEP_BIT], 1'b0);
`endif

      cyc(2);
      chk("sb_enter_empty", sb_enter.size(), 0);
      chk("sb_led_empty", sb_led.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
